// File: rtl/adv_input_pkg.sv
// ---------------------------------------------------------------------------
// adv_input_pkg
// Shared constants for the direction input path of the game.
//   DIR_N/S/E/W    : bit positions of each direction in the 4-bit button and
//                    request vectors (N is the MSB, W the LSB).
//   MOVE_COUNT_W   : width of the saturating move counter.
//   MOVE_COUNT_MAX : saturation value of the move counter.
//   grant_fixed_priority() : one-hot fixed-priority arbiter, N > S > E > W.
// ---------------------------------------------------------------------------
package adv_input_pkg;

  localparam int NUM_DIRS     = 4;
  localparam int DIR_N        = 3;
  localparam int DIR_S        = 2;
  localparam int DIR_E        = 1;
  localparam int DIR_W        = 0;

  localparam int MOVE_COUNT_W = 8;
  localparam logic [MOVE_COUNT_W-1:0] MOVE_COUNT_MAX = 8'd255;

  // Picks the single highest-priority request; everything else is dropped.
  function automatic logic [NUM_DIRS-1:0] grant_fixed_priority(
    input logic [NUM_DIRS-1:0] req
  );
    logic [NUM_DIRS-1:0] grant;
    grant = 4'b0000;
    if (req[DIR_N]) begin
      grant[DIR_N] = 1'b1;
    end else if (req[DIR_S]) begin
      grant[DIR_S] = 1'b1;
    end else if (req[DIR_E]) begin
      grant[DIR_E] = 1'b1;
    end else if (req[DIR_W]) begin
      grant[DIR_W] = 1'b1;
    end else begin
      grant = 4'b0000;
    end
    return grant;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One push-button channel: 2-flop synchronizer, consecutive-sample debounce
// counter, debounced level and a registered one-cycle rise pulse that fires
// in the same edge the debounced level goes 0->1.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   btn   : raw asynchronous, bouncy button (active-high)
//   rise  : one-cycle pulse on a debounced press
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;
  logic             rise_r;

  logic             level_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             rise_nxt_s;

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Debounce decision: the level only follows the synchronized input after
  // DEBOUNCE_CYCLES consecutive mismatching samples; any agreeing sample
  // restarts the count, which is what rejects short glitches.
  always_comb begin
    level_nxt_s = level_r;
    cnt_nxt_s   = cnt_r;
    rise_nxt_s  = 1'b0;
    if (sync2_r == level_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      level_nxt_s = sync2_r;
      cnt_nxt_s   = CNT_ZERO;
      // A change is committed here; it is a press only when heading to 1.
      rise_nxt_s  = sync2_r;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Debounce state and rise pulse registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
      rise_r  <= 1'b0;
    end else begin
      level_r <= level_nxt_s;
      cnt_r   <= cnt_nxt_s;
      rise_r  <= rise_nxt_s;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/direction_input_conditioner.sv
// ---------------------------------------------------------------------------
// direction_input_conditioner
// Turns four bouncy direction buttons into clean one-cycle move pulses for
// the game FSM. Each button is debounced by its own btn_debounce; same-cycle
// presses are resolved N > S > E > W (losers are dropped), and all new moves
// are discarded while the game is halted.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous, active-low reset
//   btn[3:0]   : raw buttons, bit3=N bit2=S bit1=E bit0=W, active-high
//   halt       : game-over hold (win|die), suppresses new moves
//   n, s, e, w : registered one-cycle move pulses, at most one high
//   move_count : moves issued since reset, saturating at 255
// ---------------------------------------------------------------------------
module direction_input_conditioner
  import adv_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              btn,
  input  logic                    halt,
  output logic                    n,
  output logic                    s,
  output logic                    e,
  output logic                    w,
  output logic [MOVE_COUNT_W-1:0] move_count
);

  logic [NUM_DIRS-1:0]     rise_s;
  logic [NUM_DIRS-1:0]     grant_s;
  logic [NUM_DIRS-1:0]     move_r;
  logic [MOVE_COUNT_W-1:0] move_count_r;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[i]),
      .rise  (rise_s[i])
    );
  end

  // Arbitration and halt gating. Rise pulses last one cycle, so a request
  // dropped here (loser or halted) is gone for good.
  always_comb begin
    grant_s = 4'b0000;
    if (halt) begin
      grant_s = 4'b0000;
    end else begin
      grant_s = grant_fixed_priority(rise_s);
    end
  end

  // Registered move pulses and saturating move counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      move_r       <= 4'b0000;
      move_count_r <= {MOVE_COUNT_W{1'b0}};
    end else begin
      move_r <= grant_s;
      if ((grant_s != 4'b0000) && (move_count_r != MOVE_COUNT_MAX)) begin
        move_count_r <= move_count_r + MOVE_COUNT_W'(1);
      end else begin
        move_count_r <= move_count_r;
      end
    end
  end

  assign n          = move_r[DIR_N];
  assign s          = move_r[DIR_S];
  assign e          = move_r[DIR_E];
  assign w          = move_r[DIR_W];
  assign move_count = move_count_r;

endmodule

// File: tb/tb_direction_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_direction_input_conditioner
// Directed stimulus with a scoreboard: each press that should produce a move
// pushes {direction, cycle, move_count} into a queue; a monitor on the
// falling edge pops and compares whenever any move output is high.
// ---------------------------------------------------------------------------
module tb_direction_input_conditioner;
  import adv_input_pkg::*;

  localparam int DEB = 4;
  localparam int LAT = 3 + DEB;  // drive at negedge after edge c -> pulse seen after edge c+LAT

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       halt = 1'b0;
  logic       n, s, e, w;
  logic [7:0] move_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] dir;
    int         at_cyc;
    int         mc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  direction_input_conditioner #(
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .halt       (halt),
    .n          (n),
    .s          (s),
    .e          (e),
    .w          (w),
    .move_count (move_count)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [3:0] dir, input int mc);
    exp_t x;
    x.dir    = dir;
    x.at_cyc = cyc + LAT;
    x.mc     = mc;
    sb.push_back(x);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 60) begin
      tick(1);
      budget++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d pulses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every cycle with a move pulse must match the next expectation.
  always @(negedge clk) begin
    logic [3:0] got;
    exp_t       ex;
    got = {n, s, e, w};
    if (got != 4'b0000) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: actual dirs %b at cycle %0d, required none", got, cyc);
      end else begin
        ex = sb.pop_front();
        check("pulse_dir", int'(got), int'(ex.dir));
        check("pulse_cycle", cyc, ex.at_cyc);
        check("pulse_move_count", int'(move_count), ex.mc);
      end
    end
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    int mc_exp;

    // Reset state.
    reset = 1'b0;
    btn   = 4'b0000;
    halt  = 1'b0;
    tick(3);
    check("reset_dirs", int'({n, s, e, w}), 0);
    check("reset_move_count", int'(move_count), 0);
    reset = 1'b1;
    tick(3);

    // Clean N press.
    btn[DIR_N] = 1'b1;
    expect_pulse(4'b1000, 1);
    tick(12);
    btn = 4'b0000;
    tick(12);
    drain();
    check("mc_after_n", int'(move_count), 1);

    // Bouncy E press: latency counts from the final rising edge.
    btn[DIR_E] = 1'b1; tick(1);
    btn[DIR_E] = 1'b0; tick(1);
    btn[DIR_E] = 1'b1; tick(1);
    btn[DIR_E] = 1'b0; tick(1);
    btn[DIR_E] = 1'b1;
    expect_pulse(4'b0010, 2);
    tick(12);
    btn = 4'b0000;
    tick(12);
    drain();

    // Glitch one sample short of the debounce length: no move.
    btn[DIR_N] = 1'b1;
    tick(DEB - 1);
    btn = 4'b0000;
    tick(12);
    check("mc_after_glitch", int'(move_count), 2);

    // S and W together: S wins, W dropped.
    btn = 4'b0101;
    expect_pulse(4'b0100, 3);
    tick(12);
    btn = 4'b0000;
    tick(12);
    drain();
    check("mc_after_sw", int'(move_count), 3);

    // N, E and W together: N wins.
    btn = 4'b1011;
    expect_pulse(4'b1000, 4);
    tick(12);
    btn = 4'b0000;
    tick(12);
    drain();

    // Halt: press during halt, release halt while held -> nothing.
    halt = 1'b1;
    btn[DIR_N] = 1'b1;
    tick(12);
    halt = 1'b0;
    tick(12);
    btn = 4'b0000;
    tick(12);
    check("mc_after_halt", int'(move_count), 4);
    btn[DIR_N] = 1'b1;
    expect_pulse(4'b1000, 5);
    tick(12);
    btn = 4'b0000;
    tick(12);
    drain();

    // Saturation: 260 alternating N/W presses.
    mc_exp = 5;
    for (int i = 0; i < 260; i++) begin
      if (mc_exp < 255) mc_exp++;
      if (i % 2 == 0) begin
        btn = 4'b1000;
        expect_pulse(4'b1000, mc_exp);
      end else begin
        btn = 4'b0001;
        expect_pulse(4'b0001, mc_exp);
      end
      tick(8);
      btn = 4'b0000;
      tick(8);
    end
    drain();
    check("mc_saturated", int'(move_count), 255);

    // Reset mid-debounce, button released with reset: no move.
    btn[DIR_N] = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("midreset_dirs", int'({n, s, e, w}), 0);
    check("midreset_move_count", int'(move_count), 0);
    reset = 1'b1;
    btn   = 4'b0000;
    tick(15);
    check("mc_after_aborted_press", int'(move_count), 0);

    // Reset mid-debounce, button held through: full latency after release.
    btn[DIR_N] = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(1);
    check("heldreset_dirs", int'({n, s, e, w}), 0);
    reset = 1'b1;
    expect_pulse(4'b1000, 1);
    tick(12);
    btn = 4'b0000;
    tick(12);
    drain();
    check("mc_after_held_reset", int'(move_count), 1);

    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
